// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front-end: port bundles, register record, FSM states.
// Compile with FETCH_PERF_EN defined to add the perf counter outputs to fetch_unit.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {CLR, REQ, HOLD, DROP} fetch_state;

    typedef struct packed {
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        imem_ready;
        logic [31:0] imem_rdata;
        logic        buf_stall;
    } fetch_in_type;

    typedef struct packed {
        logic        imem_valid;
        logic [31:0] imem_addr;
        logic        buf_ready;
        logic [31:0] buf_pc;
        logic [31:0] buf_rdata;
        logic        buf_clear;
        logic        buf_align;
    } fetch_out_type;

    typedef struct packed {
        fetch_state  state;
        logic [31:0] fpc;
        logic        align;
        logic [31:0] drop_addr;
        logic        skid_valid;
        logic [31:0] skid_pc;
        logic [31:0] skid_data;
    } fetch_reg_type;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: word-aligned imem requests, one-entry skid, redirect handling.
// Optional FETCH_PERF_EN adds perf_words / perf_drops counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        reset,
    input  logic        clock,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_words,
    output logic [31:0] perf_drops,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        buf_stall,
    output logic        buf_ready,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_rdata,
    output logic        buf_clear,
    output logic        buf_align
);

    localparam fetch_reg_type RES = '{
        state:      CLR,
        fpc:        {RESET_PC[31:2], 2'b00},
        align:      RESET_PC[1],
        drop_addr:  32'h0,
        skid_valid: 1'b0,
        skid_pc:    32'h0,
        skid_data:  32'h0
    };

    fetch_reg_type r, rin;
    fetch_in_type  d;
    fetch_out_type o;

    // Bit 0 of a halfword-aligned target carries no information.
    logic unused_pc_bit;
    assign unused_pc_bit = d.redirect_pc[0];

    assign d = '{
        redirect_valid: redirect_valid,
        redirect_pc:    redirect_pc,
        imem_ready:     imem_ready,
        imem_rdata:     imem_rdata,
        buf_stall:      buf_stall
    };

    always_comb begin
        fetch_reg_type v;
        v           = r;
        o           = '0;
        o.imem_addr = r.fpc;

        unique case (r.state)
            CLR: begin
                o.buf_clear = 1'b1;
                o.buf_align = r.align;
                v.state     = d.buf_stall ? HOLD : REQ;
            end
            REQ: begin
                o.imem_valid = 1'b1;
                if (d.imem_ready) begin
                    v.fpc = r.fpc + 32'd4;
                    if (d.buf_stall) begin
                        v.skid_valid = 1'b1;
                        v.skid_pc    = r.fpc;
                        v.skid_data  = d.imem_rdata;
                        v.state      = HOLD;
                    end else begin
                        o.buf_ready = 1'b1;
                        o.buf_pc    = r.fpc;
                        o.buf_rdata = d.imem_rdata;
                    end
                end
            end
            HOLD: begin
                if (r.skid_valid && !d.buf_stall) begin
                    o.buf_ready  = 1'b1;
                    o.buf_pc     = r.skid_pc;
                    o.buf_rdata  = r.skid_data;
                    v.skid_valid = 1'b0;
                end
                if (!d.buf_stall) begin
                    v.state = REQ;
                end
            end
            DROP: begin
                // The abandoned request stays on the bus until imem accepts it.
                o.imem_valid = 1'b1;
                o.imem_addr  = r.drop_addr;
                if (d.imem_ready) begin
                    v.state = CLR;
                end
            end
            default: v.state = CLR;
        endcase

        if (d.redirect_valid) begin
            o.buf_ready  = 1'b0;
            o.buf_pc     = 32'h0;
            o.buf_rdata  = 32'h0;
            v.fpc        = {d.redirect_pc[31:2], 2'b00};
            v.align      = d.redirect_pc[1];
            v.skid_valid = 1'b0;
            if (r.state == REQ && !d.imem_ready) begin
                v.state     = DROP;
                v.drop_addr = r.fpc;
            end else if (r.state == DROP && !d.imem_ready) begin
                v.state = DROP;
            end else begin
                v.state = CLR;
            end
        end

        if (!reset) begin
            o           = '0;
            o.imem_addr = RES.fpc;
        end

        rin = v;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r <= RES;
        end else begin
            r <= rin;
        end
    end

    assign imem_valid = o.imem_valid;
    assign imem_addr  = o.imem_addr;
    assign buf_ready  = o.buf_ready;
    assign buf_pc     = o.buf_pc;
    assign buf_rdata  = o.buf_rdata;
    assign buf_clear  = o.buf_clear;
    assign buf_align  = o.buf_align;

`ifdef FETCH_PERF_EN
    logic        drop_word;
    logic [31:0] words_q, drops_q;

    // A word is lost when a redirect flushes the skid or kills a returning fetch.
    assign drop_word = (d.redirect_valid && r.skid_valid)
                     || (d.redirect_valid && r.state == REQ && d.imem_ready)
                     || (r.state == DROP && d.imem_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            words_q <= 32'h0;
            drops_q <= 32'h0;
        end else begin
            words_q <= words_q + {31'h0, o.buf_ready};
            drops_q <= drops_q + {31'h0, drop_word};
        end
    end

    assign perf_words = words_q;
    assign perf_drops = drops_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model checked every cycle,
// plus hand-computed literal pins on the directed scenario.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0102;

    logic        reset, clock;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        buf_stall, buf_ready;
    logic [31:0] buf_pc, buf_rdata;
    logic        buf_clear, buf_align;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_words, perf_drops;
    bit          pf_en;
    logic [31:0] pf_words, pf_drops;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Literal pins set by the stimulus for the current cycle (-1 / 0 enable = unchecked).
    int          p_valid, p_ready, p_clear, p_align;
    bit          pa_en, pp_en, pd_en;
    logic [31:0] pa, pp, pd;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .reset          (reset),
        .clock          (clock),
`ifdef FETCH_PERF_EN
        .perf_words     (perf_words),
        .perf_drops     (perf_drops),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_valid     (imem_valid),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .buf_stall      (buf_stall),
        .buf_ready      (buf_ready),
        .buf_pc         (buf_pc),
        .buf_rdata      (buf_rdata),
        .buf_clear      (buf_clear),
        .buf_align      (buf_align)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'h0, act}, {31'h0, exp});
    endtask

    // Reference model and the single compare process.
    initial begin
        logic [31:0] m_fpc, m_words, m_drops;
        logic        m_align, m_clear, m_fetching;
        logic [31:0] m_abandon[$];
        logic [31:0] m_skid_pc[$];
        logic [31:0] m_skid_dat[$];
        logic        e_valid, e_ready, e_clear, e_align;
        logic [31:0] e_addr, e_pc, e_dat;
        m_fpc = 32'h0; m_words = 32'h0; m_drops = 32'h0;
        m_align = 1'b0; m_clear = 1'b0; m_fetching = 1'b0;
        forever begin
            @(negedge clock);
            e_valid = 1'b0; e_ready = 1'b0; e_clear = 1'b0; e_align = 1'b0;
            e_addr = m_fpc; e_pc = 32'h0; e_dat = 32'h0;
            if (!reset) begin
                e_addr = {RST_PC[31:2], 2'b00};
            end else if (m_abandon.size() != 0) begin
                e_valid = 1'b1;
                e_addr  = m_abandon[0];
            end else if (m_clear) begin
                e_clear = 1'b1;
                e_align = m_align;
            end else if (m_fetching) begin
                e_valid = 1'b1;
                if (imem_ready && !buf_stall && !redirect_valid) begin
                    e_ready = 1'b1; e_pc = m_fpc; e_dat = imem_rdata;
                end
            end else if (m_skid_pc.size() != 0 && !buf_stall && !redirect_valid) begin
                e_ready = 1'b1; e_pc = m_skid_pc[0]; e_dat = m_skid_dat[0];
            end

            chk1("imem_valid", imem_valid, e_valid);
            chk1("buf_ready", buf_ready, e_ready);
            chk1("buf_clear", buf_clear, e_clear);
            if (e_valid || !reset) chk("imem_addr", imem_addr, e_addr);
            if (e_ready || !reset) begin
                chk("buf_pc", buf_pc, e_pc);
                chk("buf_rdata", buf_rdata, e_dat);
            end
            if (e_clear || !reset) chk1("buf_align", buf_align, e_align);
`ifdef FETCH_PERF_EN
            if (reset) begin
                chk("perf_words", perf_words, m_words);
                chk("perf_drops", perf_drops, m_drops);
            end
            if (pf_en) begin
                chk("lit_perf_words", perf_words, pf_words);
                chk("lit_perf_drops", perf_drops, pf_drops);
            end
`endif
            if (p_valid >= 0) chk1("lit_imem_valid", imem_valid, p_valid[0]);
            if (p_ready >= 0) chk1("lit_buf_ready", buf_ready, p_ready[0]);
            if (p_clear >= 0) chk1("lit_buf_clear", buf_clear, p_clear[0]);
            if (p_align >= 0) chk1("lit_buf_align", buf_align, p_align[0]);
            if (pa_en) chk("lit_imem_addr", imem_addr, pa);
            if (pp_en) chk("lit_buf_pc", buf_pc, pp);
            if (pd_en) chk("lit_buf_rdata", buf_rdata, pd);

            if (!reset) begin
                m_fpc = {RST_PC[31:2], 2'b00}; m_align = RST_PC[1];
                m_clear = 1'b1; m_fetching = 1'b0;
                m_abandon.delete(); m_skid_pc.delete(); m_skid_dat.delete();
                m_words = 32'h0; m_drops = 32'h0;
            end else begin
                if (e_ready) m_words++;
                if (redirect_valid) begin
                    if (m_abandon.size() != 0) begin
                        if (imem_ready) begin m_drops++; m_abandon.delete(); end
                    end else if (m_fetching) begin
                        if (imem_ready) m_drops++;
                        else m_abandon.push_back(m_fpc);
                    end
                    if (m_skid_pc.size() != 0) m_drops++;
                    m_skid_pc.delete(); m_skid_dat.delete();
                    m_fpc = {redirect_pc[31:2], 2'b00};
                    m_align = redirect_pc[1];
                    m_clear = 1'b1; m_fetching = 1'b0;
                end else if (m_abandon.size() != 0) begin
                    if (imem_ready) begin m_drops++; m_abandon.delete(); end
                end else if (m_clear) begin
                    m_clear = 1'b0; m_fetching = !buf_stall;
                end else if (m_fetching) begin
                    if (imem_ready) begin
                        if (buf_stall) begin
                            m_skid_pc.push_back(m_fpc); m_skid_dat.push_back(imem_rdata);
                            m_fetching = 1'b0;
                        end
                        m_fpc = m_fpc + 32'd4;
                    end
                end else begin
                    if (m_skid_pc.size() != 0 && !buf_stall) begin
                        void'(m_skid_pc.pop_front()); void'(m_skid_dat.pop_front());
                    end
                    m_fetching = !buf_stall;
                end
            end
        end
    end

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic ir,
                         input logic [31:0] rd, input logic st);
        redirect_valid = rv; redirect_pc = rpc; imem_ready = ir; imem_rdata = rd; buf_stall = st;
        p_valid = -1; p_ready = -1; p_clear = -1; p_align = -1;
        pa_en = 1'b0; pp_en = 1'b0; pd_en = 1'b0;
`ifdef FETCH_PERF_EN
        pf_en = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_valid = 0; p_clear = 0; p_align = 0; pa_en = 1; pa = 32'h100;
        tick(); tick();
        reset = 1'b1;
        // c0: clear pulse with align from RESET_PC bit 1
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_clear = 1; p_align = 1; p_valid = 0; tick();
        // c1-c2: streaming delivery
        drive(1'b0, 32'h0, 1'b1, 32'hD000_0100, 1'b0);
        p_valid = 1; pa_en = 1; pa = 32'h100; p_ready = 1; pp_en = 1; pp = 32'h100; tick();
        drive(1'b0, 32'h0, 1'b1, 32'hD000_0104, 1'b0);
        pa_en = 1; pa = 32'h104; p_ready = 1; pp_en = 1; pp = 32'h104; tick();
        // c3-c5: stalled word goes to skid, released later
        drive(1'b0, 32'h0, 1'b1, 32'hD000_0108, 1'b1);
        p_valid = 1; pa_en = 1; pa = 32'h108; p_ready = 0; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        p_valid = 0; p_ready = 0; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_valid = 0; p_ready = 1; pp_en = 1; pp = 32'h108; pd_en = 1; pd = 32'hD000_0108; tick();
        // c6-c9: redirect with request pending, old address held then dropped
        drive(1'b1, 32'h0000_2002, 1'b0, 32'h0, 1'b0);
        p_valid = 1; pa_en = 1; pa = 32'h10C; p_ready = 0; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_valid = 1; pa_en = 1; pa = 32'h10C; tick();
        drive(1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0, 1'b0);
        p_valid = 1; pa_en = 1; pa = 32'h10C; p_ready = 0; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_clear = 1; p_align = 1; p_valid = 0; tick();
        // c10-c11: fetch at target, then redirect colliding with imem_ready
        drive(1'b0, 32'h0, 1'b1, 32'hD000_2000, 1'b0);
        p_valid = 1; pa_en = 1; pa = 32'h2000; p_ready = 1; pp_en = 1; pp = 32'h2000; tick();
        drive(1'b1, 32'h0000_3000, 1'b1, 32'hD000_2004, 1'b0);
        pa_en = 1; pa = 32'h2004; p_ready = 0; tick();
        // c12-c13: redirect during clear restarts the clear
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        p_clear = 1; p_align = 0; p_ready = 0;
`ifdef FETCH_PERF_EN
        pf_en = 1'b1; pf_words = 32'd4; pf_drops = 32'd2;
`endif
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_clear = 1; p_align = 0; tick();
        // c14-c15: fpc wraps past the top of the address space
        drive(1'b0, 32'h0, 1'b1, 32'hD0FF_FFFC, 1'b0);
        pa_en = 1; pa = 32'hFFFF_FFFC; p_ready = 1; pp_en = 1; pp = 32'hFFFF_FFFC; tick();
        drive(1'b0, 32'h0, 1'b1, 32'hD000_0000, 1'b0);
        pa_en = 1; pa = 32'h0; p_ready = 1; pp_en = 1; pp = 32'h0; tick();
        // c16-c20: skid filled, then flushed by redirect while held
        drive(1'b0, 32'h0, 1'b1, 32'hD000_0004, 1'b1);
        pa_en = 1; pa = 32'h4; p_ready = 0; tick();
        drive(1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0);
        p_valid = 0; p_ready = 0; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_clear = 1; p_align = 0; tick();
        drive(1'b0, 32'h0, 1'b1, 32'hD000_0040, 1'b0);
        pa_en = 1; pa = 32'h40; p_ready = 1; pp_en = 1; pp = 32'h40; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_valid = 1; pa_en = 1; pa = 32'h44; tick();
        // Mid-run reset forces reset outputs, then the clear pulse again
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        p_valid = 0; p_ready = 0; p_clear = 0; pa_en = 1; pa = 32'h100; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_clear = 1; p_align = 1; tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        p_valid = 1; pa_en = 1; pa = 32'h100; tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
